// File: rtl/regfile_write_arbiter_if.sv
// Write-request bundle between the two writeback requesters, the arbiter and the
// register-file write port.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 64
);
  logic                     a_valid;
  logic [4:0]               a_rd;
  logic [DATA_W-1:0]        a_data;
  logic                     a_ready;
  logic                     b_valid;
  logic [4:0]               b_rd;
  logic [DATA_W-1:0]        b_data;
  logic                     b_ready;
  logic                     wr_en;
  logic [4:0]               wr_rd;
  logic signed [DATA_W-1:0] wr_data;
  logic [3:0]               starve_cnt;

  // Requester/observer side.
  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, wr_en, wr_rd, wr_data, starve_cnt
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, wr_en, wr_rd, wr_data, starve_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: A has priority, B is force-granted after
// waiting STARVE_MAX cycles. Write port is registered with one cycle of latency.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  regfile_write_arbiter_if.slave  bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic                     a_ready, b_ready, starve_hit;
  logic [4:0]               sel_rd;
  logic [DATA_W-1:0]        sel_data;
  logic                     wr_en_d, wr_en_q;
  logic [4:0]               wr_rd_d, wr_rd_q;
  logic signed [DATA_W-1:0] wr_data_d, wr_data_q;
  logic [3:0]               starve_d, starve_q;

  always_comb begin
    starve_hit = (starve_q == StarveMax);
    // Readies are gated by reset so nothing is accepted while rst_n is low.
    a_ready    = rst_n && bus.a_valid && !(bus.b_valid && starve_hit);
    b_ready    = rst_n && bus.b_valid && (starve_hit || !bus.a_valid);

    sel_rd     = b_ready ? bus.b_rd   : bus.a_rd;
    sel_data   = b_ready ? bus.b_data : bus.a_data;

    // x0 writes complete the handshake but never reach the register file.
    wr_en_d    = (a_ready || b_ready) && (sel_rd != 5'd0);
    wr_rd_d    = wr_en_d ? sel_rd : wr_rd_q;
    wr_data_d  = wr_en_d ? $signed(sel_data) : wr_data_q;

    if (bus.b_valid && !b_ready) begin
      starve_d = starve_hit ? starve_q : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_rd_q   <= 5'd0;
      wr_data_q <= '0;
      starve_q  <= 4'd0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      starve_q  <= starve_d;
    end
  end

  assign bus.a_ready    = a_ready;
  assign bus.b_ready    = b_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_rd      = wr_rd_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.starve_cnt = starve_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: request queues drive both requesters, a
// transaction-level model predicts every output each cycle, literal checks pin the model.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned SM = 4;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(DW)) bus ();

  regfile_write_arbiter #(.DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  req_t qa[$];
  req_t qb[$];

  // Transaction-level model state.
  bit            m_known = 0;
  logic          m_wr_en;
  logic [4:0]    m_wr_rd;
  logic [DW-1:0] m_wr_data;
  int            m_starve;
  logic [DW-1:0] m_mem[32];
  logic [DW-1:0] dut_mem[32];

  // Observations from the most recent step (sampled before its clock edge).
  logic          o_a_ready, o_b_ready, o_wr_en;
  logic [4:0]    o_wr_rd;
  logic [DW-1:0] o_wr_data;
  logic [3:0]    o_starve;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive queue heads, compare against the model, advance.
  task automatic step();
    logic          av, bv, e_a, e_b;
    logic [4:0]    rd;
    logic [DW-1:0] data;
    av = (qa.size() > 0);
    bv = (qb.size() > 0);
    bus.a_valid = av;
    bus.b_valid = bv;
    if (av) begin bus.a_rd = qa[0].rd; bus.a_data = qa[0].data; end
    if (bv) begin bus.b_rd = qb[0].rd; bus.b_data = qb[0].data; end
    #1;
    e_a = rst_n && av && !(bv && m_starve == SM);
    e_b = rst_n && bv && (m_starve == SM || !av);
    chk("a_ready", 64'(bus.a_ready), 64'(e_a));
    chk("b_ready", 64'(bus.b_ready), 64'(e_b));
    if (m_known) begin
      chk("wr_en",      64'(bus.wr_en),      64'(m_wr_en));
      chk("wr_rd",      64'(bus.wr_rd),      64'(m_wr_rd));
      chk("wr_data",    64'(bus.wr_data),    m_wr_data);
      chk("starve_cnt", 64'(bus.starve_cnt), 64'(m_starve));
    end
    o_a_ready = bus.a_ready;
    o_b_ready = bus.b_ready;
    o_wr_en   = bus.wr_en;
    o_wr_rd   = bus.wr_rd;
    o_wr_data = bus.wr_data;
    o_starve  = bus.starve_cnt;
    if (bus.wr_en === 1'b1) dut_mem[bus.wr_rd] = bus.wr_data;
    @(posedge clk);
    if (!rst_n) begin
      m_known = 1; m_wr_en = 0; m_wr_rd = 0; m_wr_data = 0; m_starve = 0;
    end else begin
      if (e_a || e_b) begin
        rd   = e_b ? bus.b_rd   : bus.a_rd;
        data = e_b ? bus.b_data : bus.a_data;
        m_wr_en = (rd != 0);
        if (rd != 0) begin
          m_wr_rd = rd; m_wr_data = data; m_mem[rd] = data;
        end
      end else begin
        m_wr_en = 0;
      end
      m_starve = (bv && !e_b) ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
    end
    if (o_a_ready === 1'b1) void'(qa.pop_front());
    if (o_b_ready === 1'b1) void'(qb.pop_front());
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] seq[6];
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; dut_mem[i] = '0; end
    rst_n = 1'b0;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_wr_en", 64'(o_wr_en), 64'd0);
    chk("reset_starve", 64'(o_starve), 64'd0);

    // A alone: rd 5, data 0x1234.
    qa.push_back('{rd: 5'd5, data: 64'h1234});
    step();
    chk("a_alone_ready", 64'(o_a_ready), 64'd1);
    step();
    chk("a_alone_wr_en", 64'(o_wr_en), 64'd1);
    chk("a_alone_wr_rd", 64'(o_wr_rd), 64'd5);
    chk("a_alone_wr_data", o_wr_data, 64'h1234);

    // A rd 7 then idle: one-cycle pulse, rd held.
    qa.push_back('{rd: 5'd7, data: 64'h77});
    step(); step();
    chk("pulse_wr_en", 64'(o_wr_en), 64'd1);
    step();
    chk("pulse_off", 64'(o_wr_en), 64'd0);
    chk("pulse_rd_held", 64'(o_wr_rd), 64'd7);

    // B alone to x0: handshake completes, write dropped.
    qb.push_back('{rd: 5'd0, data: 64'hFF});
    step();
    chk("x0_b_ready", 64'(o_b_ready), 64'd1);
    step();
    chk("x0_wr_en", 64'(o_wr_en), 64'd0);

    // Both continuously valid: A four times, then forced B, then A resumes.
    for (int i = 0; i < 6; i++) qa.push_back('{rd: 5'(10 + i), data: 64'(100 + i)});
    qb.push_back('{rd: 5'd20, data: 64'hB0B});
    for (int i = 0; i < 6; i++) begin
      step();
      seq[i] = o_starve;
      if (i == 4) chk("starve_b_ready", 64'(o_b_ready), 64'd1);
      if (i == 5) chk("starve_a_resume", 64'(o_a_ready), 64'd1);
    end
    chk("starve_seq1", 64'(seq[1]), 64'd1);
    chk("starve_seq3", 64'(seq[3]), 64'd3);
    chk("starve_seq4", 64'(seq[4]), 64'd4);
    chk("starve_seq5", 64'(seq[5]), 64'd0);
    drain(20);

    // Same rd from both: A first, then B; B's value survives.
    step();
    qa.push_back('{rd: 5'd3, data: 64'd1});
    qb.push_back('{rd: 5'd3, data: 64'd2});
    step();
    chk("same_rd_a_first", 64'(o_a_ready), 64'd1);
    step();
    chk("same_rd_b_second", 64'(o_b_ready), 64'd1);
    chk("same_rd_a_written", o_wr_data, 64'd1);
    step();
    chk("same_rd_b_written", o_wr_data, 64'd2);
    chk("reg3_final", dut_mem[3], 64'd2);

    // Reset right after an A transfer; a request stays pending through reset.
    qa.push_back('{rd: 5'd9, data: 64'hAB});
    step();
    qa.push_back('{rd: 5'd10, data: 64'hCD});
    rst_n = 1'b0;
    step();
    chk("rst_a_ready", 64'(o_a_ready), 64'd0);
    step();
    chk("rst_wr_en", 64'(o_wr_en), 64'd0);
    chk("rst_wr_rd", 64'(o_wr_rd), 64'd0);
    chk("rst_wr_data", o_wr_data, 64'd0);
    chk("rst_ready_hold", 64'(o_a_ready), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_a_ready", 64'(o_a_ready), 64'd1);
    chk("post_rst_starve", 64'(o_starve), 64'd0);

    // Mixed back-to-back traffic from both sides.
    for (int i = 0; i < 4; i++) begin
      qa.push_back('{rd: 5'(1 + 2 * i), data: 64'(32'hA000 + i)});
      qb.push_back('{rd: 5'(2 + 2 * i), data: 64'(32'hB000 + i)});
    end
    drain(40);
    step(); step();
    for (int r = 1; r < 32; r++) chk($sformatf("regfile_x%0d", r), dut_mem[r], m_mem[r]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of all write-data buses.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive cycles requester B may wait before it is force-granted; legal range 1..15.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have ports a_valid  input  1; a_rd  input  5; a_data  input  DATA_W: requester A (ALU writeback) write request.
REQ-006 SHALL have port a_ready  output  1: A transfer accepted this cycle.
REQ-007 SHALL have ports b_valid  input  1; b_rd  input  5; b_data  input  DATA_W: requester B (load/multi-cycle unit) write request.
REQ-008 SHALL have port b_ready  output  1: B transfer accepted this cycle.
REQ-009 SHALL have ports wr_en  output  1; wr_rd  output  5; wr_data  output  DATA_W (signed): registered write port driving the register file's reg_write/rd/write_data.
REQ-010 SHALL have port starve_cnt  output  4: current B wait count, for debug and coverage.

Function
REQ-011 SHALL assert at most one of a_ready/b_ready in any cycle; both are combinational from valids and starve_cnt.
REQ-012 SHALL grant, in priority order: B if b_valid and starve_cnt == STARVE_MAX; else A if a_valid; else B if b_valid; else none.
REQ-013 SHALL define a transfer as valid && ready on the same edge; the requester holds valid, rd and data stable until its transfer completes.
REQ-014 SHALL, on the edge after a transfer with rd != 0, set wr_en=1 and load wr_rd/wr_data from the granted requester's payload (latency exactly 1 cycle).
REQ-015 SHALL, on a transfer with rd == 0, complete the handshake but drive wr_en=0 next cycle (x0 writes discarded).
REQ-016 SHALL drive wr_en=0 in any cycle following a no-transfer cycle; wr_rd/wr_data then hold their previous values.
REQ-017 SHALL increment starve_cnt by 1 per cycle when b_valid && !b_ready, saturating at STARVE_MAX.
REQ-018 SHALL clear starve_cnt to 0 on a B transfer or any cycle with b_valid low.
REQ-019 SHALL, when A and B are both valid with the same rd, serve them in grant order; the later write wins in the register file; no merging.
REQ-020 SHALL sustain one transfer per cycle with back-to-back transfers from either or alternating requesters.

Reset
REQ-021 SHALL, while rst_n is low at an edge, set wr_en=0, wr_rd=0, wr_data=0, starve_cnt=0.
REQ-022 SHALL hold a_ready=0 and b_ready=0 combinationally while rst_n is low, so no transfer occurs during reset.
REQ-023 SHALL drop an output write in flight when reset hits mid-operation: wr_en=0 on the edge after rst_n low, regardless of prior transfer.
REQ-024 SHALL resume arbitration per REQ-012 on the first cycle with rst_n high, starve_cnt starting at 0.

Verification
REQ-025 SHALL cover: A alone valid, a_rd=5, a_data=0x1234 -> a_ready=1 that cycle; next cycle wr_en=1, wr_rd=5, wr_data=0x1234.
REQ-026 SHALL cover: A and B continuously valid, STARVE_MAX=4 -> A granted 4 cycles, starve_cnt 1,2,3,4, cycle 5 b_ready=1, then starve_cnt=0 and A resumes.
REQ-027 SHALL cover: B alone valid, b_rd=0, b_data=0xFF -> b_ready=1; next cycle wr_en=0.
REQ-028 SHALL cover: A transfer rd=7 then idle cycle -> wr_en=1 one cycle only, then wr_en=0 with wr_rd=7 held.
REQ-029 SHALL cover: reset asserted the edge after an A transfer -> wr_en=0, wr_rd=0, wr_data=0, a_ready=b_ready=0 throughout reset.
REQ-030 SHALL cover: A rd=3 data=1 and B rd=3 data=2 both valid, starve_cnt=0 -> A written first, then B; final register 3 value is 2.
